// File: rtl/touch_if.sv
// Touch event bus: raw panel samples in, debounced/averaged tap events out.
interface touch_if;
   logic        raw_valid;
   logic        raw_pressed;
   logic [10:0] raw_x;
   logic [10:0] raw_y;
   logic [31:0] touch_data;
   logic        touch_valid;
   logic        touch_release;
   logic        touch_active;

   modport master (
      input  raw_valid, raw_pressed, raw_x, raw_y,
      output touch_data, touch_valid, touch_release, touch_active
   );

   modport slave (
      output raw_valid, raw_pressed, raw_x, raw_y,
      input  touch_data, touch_valid, touch_release, touch_active
   );
endinterface

// File: rtl/touch_event_gen.sv
// Debounces touch press/release, averages 2^AVG_LOG2 in-range samples per press and
// publishes one packed tap event; touch_data returns to 0 after a debounced release.
module touch_event_gen #(
   parameter int X_MAX           = 1023,
   parameter int Y_MAX           = 599,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int AVG_LOG2        = 2
) (
   input  logic     clk,
   input  logic     rst,
   touch_if.master  tif
);
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SW = 11 + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam logic [10:0]   XM     = 11'(X_MAX);
   localparam logic [10:0]   YM     = 11'(Y_MAX);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [NW-1:0] N_LAST = NW'((1 << AVG_LOG2) - 1);

   typedef enum logic [2:0] {IDLE, PRESS_DB, ACCUM, PRESSED, RELEASE_DB} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   sum_x_q, sum_y_q, sx_nx, sy_nx;
   logic [NW-1:0]   n_q;
   logic [31:0]     data_q;
   logic            valid_q, release_q;
   logic            in_rng, rel_s, prs_s, cnt_done, acc_hit;
   logic            active_c, publish, retire;

   // (0,0) is reserved as the release code, so it never counts as a touch
   assign prs_s    = tif.raw_valid & tif.raw_pressed;
   assign rel_s    = tif.raw_valid & ~tif.raw_pressed;
   assign in_rng   = prs_s & (tif.raw_x <= XM) & (tif.raw_y <= YM) &
                     ~((tif.raw_x == 11'd0) & (tif.raw_y == 11'd0));
   assign cnt_done = (cnt_q == CNT_TC);
   assign acc_hit  = in_rng & (n_q == N_LAST);
   assign sx_nx    = sum_x_q + SW'(tif.raw_x);
   assign sy_nx    = sum_y_q + SW'(tif.raw_y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // raw samples take priority over a debounce terminal count in the same cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (in_rng) state_d = PRESS_DB;
         PRESS_DB:   if (rel_s) state_d = IDLE;
                     else if (cnt_done) state_d = ACCUM;
         ACCUM:      if (rel_s) state_d = IDLE;
                     else if (acc_hit) state_d = PRESSED;
         PRESSED:    if (rel_s) state_d = RELEASE_DB;
         RELEASE_DB: if (prs_s) state_d = PRESSED;
                     else if (cnt_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      active_c = (state_q == PRESSED) || (state_q == RELEASE_DB);
      publish  = (state_q == ACCUM) && acc_hit;
      retire   = (state_q == RELEASE_DB) && !prs_s && cnt_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         sum_x_q   <= '0;
         sum_y_q   <= '0;
         n_q       <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         if ((state_q == PRESS_DB || state_q == RELEASE_DB) && state_d == state_q)
            cnt_q <= cnt_q + 1'b1;
         else
            cnt_q <= '0;

         // sums only live inside ACCUM; leaving it discards any partial average
         if (state_q != ACCUM) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            n_q     <= '0;
         end else if (in_rng) begin
            sum_x_q <= sx_nx;
            sum_y_q <= sy_nx;
            n_q     <= n_q + 1'b1;
         end

         if (publish)
            data_q <= {5'b0, sx_nx[SW-1:AVG_LOG2], 5'b0, sy_nx[SW-1:AVG_LOG2]};
         else if (retire)
            data_q <= 32'h0;

         valid_q   <= publish;
         release_q <= retire;
      end
   end

   assign tif.touch_data    = data_q;
   assign tif.touch_valid   = valid_q;
   assign tif.touch_release = release_q;
   assign tif.touch_active  = active_c;
endmodule

// File: tb/tb_touch_event_gen.sv
// Bench for touch_event_gen: vector table, hand-written corner sequences, random vs model.
module tb_touch_event_gen;
   localparam int DB = 4;
   localparam int AL = 2;
   localparam int N  = 1 << AL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   touch_if tif();

   touch_event_gen #(.X_MAX(1023), .Y_MAX(599), .DEBOUNCE_CYCLES(DB), .AVG_LOG2(AL)) dut (
      .clk (clk),
      .rst (rst),
      .tif (tif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v, p;
      logic [10:0] x, y;
      logic [31:0] d;
      logic tv, tr, ta;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic v, p, input logic [10:0] x, y,
                      input logic [31:0] d, input logic tv, tr, ta);
      vec_t e;
      e.v = v; e.p = p; e.x = x; e.y = y; e.d = d; e.tv = tv; e.tr = tr; e.ta = ta;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, p, input logic [10:0] x, y);
      @(negedge clk);
      tif.raw_valid = v; tif.raw_pressed = p; tif.raw_x = x; tif.raw_y = y;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 11'd0, 11'd0);
   endtask

   task automatic release_all();
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      idle(DB);
      chk("release_all_data", tif.touch_data, 32'h0);
   endtask

   // reference model: phases of a touch, accepted samples kept in a queue
   int ph, age;
   int sq_x[$], sq_y[$];
   logic [31:0] m_data;
   logic m_valid, m_rel;

   function automatic logic [31:0] pack(input int x, y);
      logic [10:0] xs, ys;
      xs = 11'(x); ys = 11'(y);
      return {5'b0, xs, 5'b0, ys};
   endfunction

   task automatic model_reset();
      ph = 0; age = 0; sq_x.delete(); sq_y.delete();
      m_data = 32'h0; m_valid = 1'b0; m_rel = 1'b0;
   endtask

   task automatic model_step(input bit v, p, input int x, y);
      bit inr, rel;
      int sx, sy;
      inr = v && p && x <= 1023 && y <= 599 && !(x == 0 && y == 0);
      rel = v && !p;
      m_valid = 1'b0; m_rel = 1'b0;
      case (ph)
         0: if (inr) begin ph = 1; age = 0; end
         1: if (rel) ph = 0;
            else begin
               age++;
               if (age == DB) begin ph = 2; sq_x.delete(); sq_y.delete(); end
            end
         2: if (rel) ph = 0;
            else if (inr) begin
               sq_x.push_back(x); sq_y.push_back(y);
               if (sq_x.size() == N) begin
                  sx = 0; sy = 0;
                  foreach (sq_x[i]) begin sx += sq_x[i]; sy += sq_y[i]; end
                  m_data = pack(sx / N, sy / N);
                  m_valid = 1'b1;
                  ph = 3;
               end
            end
         3: if (rel) begin ph = 4; age = 0; end
         default:
            if (v && p) ph = 3;
            else begin
               age++;
               if (age == DB) begin ph = 0; m_data = 32'h0; m_rel = 1'b1; end
            end
      endcase
   endtask

   initial begin
      bit fdown, gp, gv;
      int gx, gy;
      tif.raw_valid = 1'b0; tif.raw_pressed = 1'b0; tif.raw_x = '0; tif.raw_y = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", tif.touch_data, 32'h0);
      chk("rst_valid", 32'(tif.touch_valid), 32'h0);
      chk("rst_release", 32'(tif.touch_release), 32'h0);
      chk("rst_active", 32'(tif.touch_active), 32'h0);
      @(negedge clk) rst = 1'b0;

      // tap at ~(103,503) then debounced release
      add(1,1,11'd100,11'd500, 32'h0,0,0,0);
      for (int i = 0; i < DB; i++) add(0,0,11'd0,11'd0, 32'h0,0,0,0);
      add(1,1,11'd100,11'd500, 32'h0,0,0,0);
      add(1,1,11'd102,11'd502, 32'h0,0,0,0);
      add(1,1,11'd104,11'd504, 32'h0,0,0,0);
      add(1,1,11'd106,11'd506, 32'h006701F7,1,0,1);
      add(0,0,11'd0,11'd0, 32'h006701F7,0,0,1);
      add(1,0,11'd0,11'd0, 32'h006701F7,0,0,1);
      for (int i = 0; i < DB - 1; i++) add(1,0,11'd0,11'd0, 32'h006701F7,0,0,1);
      add(1,0,11'd0,11'd0, 32'h0,0,1,0);
      add(0,0,11'd0,11'd0, 32'h0,0,0,0);
      foreach (tbl[i]) begin
         cyc(tbl[i].v, tbl[i].p, tbl[i].x, tbl[i].y);
         chk($sformatf("tbl%0d_data", i), tif.touch_data, tbl[i].d);
         chk($sformatf("tbl%0d_valid", i), 32'(tif.touch_valid), 32'(tbl[i].tv));
         chk($sformatf("tbl%0d_rel", i), 32'(tif.touch_release), 32'(tbl[i].tr));
         chk($sformatf("tbl%0d_active", i), 32'(tif.touch_active), 32'(tbl[i].ta));
      end

      // release during press debounce at cnt=2
      cyc(1'b1, 1'b1, 11'd300, 11'd300);
      idle(2);
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      for (int i = 0; i < 6; i++) begin
         idle(1);
         chk("pdb_abort_valid", 32'(tif.touch_valid), 32'h0);
      end
      chk("pdb_abort_data", tif.touch_data, 32'h0);

      // release on the terminal count wins: four samples afterwards must not publish
      cyc(1'b1, 1'b1, 11'd300, 11'd300);
      idle(DB - 1);
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      for (int i = 0; i < N; i++) begin
         cyc(1'b1, 1'b1, 11'd7, 11'd7);
         chk("tc_prio_valid", 32'(tif.touch_valid), 32'h0);
      end
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      chk("tc_prio_data", tif.touch_data, 32'h0);

      // release glitch in PRESSED
      cyc(1'b1, 1'b1, 11'd200, 11'd100);
      idle(DB);
      for (int i = 0; i < N; i++) cyc(1'b1, 1'b1, 11'd200, 11'd100);
      chk("glitch_pub_valid", 32'(tif.touch_valid), 32'h1);
      chk("glitch_pub_data", tif.touch_data, 32'h00C80064);
      idle(1);
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      idle(1);
      cyc(1'b1, 1'b1, 11'd900, 11'd900);
      for (int i = 0; i < 6; i++) begin
         idle(1);
         chk("glitch_rel", 32'(tif.touch_release), 32'h0);
         chk("glitch_active", 32'(tif.touch_active), 32'h1);
      end
      chk("glitch_data", tif.touch_data, 32'h00C80064);
      cyc(1'b1, 1'b0, 11'd0, 11'd0);
      idle(DB - 1);
      chk("rdb_early_rel", 32'(tif.touch_release), 32'h0);
      idle(1);
      chk("rdb_rel", 32'(tif.touch_release), 32'h1);
      chk("rdb_data", tif.touch_data, 32'h0);

      // out-of-range and (0,0) dropped in ACCUM
      cyc(1'b1, 1'b1, 11'd10, 11'd20);
      idle(DB);
      cyc(1'b1, 1'b1, 11'd1100, 11'd50);
      cyc(1'b1, 1'b1, 11'd0, 11'd0);
      for (int i = 0; i < N - 1; i++) begin
         cyc(1'b1, 1'b1, 11'd10, 11'd20);
         chk("drop_early_valid", 32'(tif.touch_valid), 32'h0);
      end
      cyc(1'b1, 1'b1, 11'd10, 11'd20);
      chk("drop_valid", 32'(tif.touch_valid), 32'h1);
      chk("drop_data", tif.touch_data, 32'h000A0014);
      idle(1);

      // async reset while PRESSED with data held
      #2 rst = 1'b1;
      #1;
      chk("arst_pressed_data", tif.touch_data, 32'h0);
      chk("arst_pressed_active", 32'(tif.touch_active), 32'h0);
      rst = 1'b0;

      // async reset in ACCUM with two samples taken; fresh press needs four new ones
      cyc(1'b1, 1'b1, 11'd1000, 11'd10);
      idle(DB);
      cyc(1'b1, 1'b1, 11'd1000, 11'd10);
      cyc(1'b1, 1'b1, 11'd1000, 11'd10);
      #2 rst = 1'b1;
      #1;
      chk("arst_accum_data", tif.touch_data, 32'h0);
      chk("arst_accum_valid", 32'(tif.touch_valid), 32'h0);
      chk("arst_accum_rel", 32'(tif.touch_release), 32'h0);
      rst = 1'b0;
      cyc(1'b1, 1'b1, 11'd8, 11'd8);
      idle(DB);
      cyc(1'b1, 1'b1, 11'd8, 11'd8);
      cyc(1'b1, 1'b1, 11'd8, 11'd8);
      cyc(1'b1, 1'b1, 11'd12, 11'd12);
      chk("post_rst_early_valid", 32'(tif.touch_valid), 32'h0);
      cyc(1'b1, 1'b1, 11'd12, 11'd12);
      chk("post_rst_valid", 32'(tif.touch_valid), 32'h1);
      chk("post_rst_data", tif.touch_data, 32'h000A000A);
      release_all();

      // random stimulus against the model
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      model_reset();
      fdown = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) fdown = ~fdown;
         gv = ($urandom_range(0, 2) != 0);
         gp = ($urandom_range(0, 14) == 0) ? ~fdown : fdown;
         if ($urandom_range(0, 9) == 0) begin gx = 0; gy = 0; end
         else begin gx = $urandom_range(0, 1150); gy = $urandom_range(0, 650); end
         cyc(gv, gp, 11'(gx), 11'(gy));
         model_step(gv, gp, gx, gy);
         chk("rnd_data", tif.touch_data, m_data);
         chk("rnd_valid", 32'(tif.touch_valid), 32'(m_valid));
         chk("rnd_rel", 32'(tif.touch_release), 32'(m_rel));
         chk("rnd_active", 32'(tif.touch_active), 32'(ph == 3 || ph == 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
